neopixel_tx_multi: RTL and testbench



---
 rtl/neopixel_tx_multi.sv | 195 +++++++++++++++++++
 tb/tb_neopixel_tx_multi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_tx_multi.sv
// WS2812/SK6812 frame serialiser: streams N pixels from a synchronous pixel RAM onto one data line.
// Optional global brightness scaling is enabled with the macro NEOPIXEL_TX_BRIGHTNESS_EN.
module neopixel_tx_multi #(
  parameter int BPP    = 24,
  parameter int ADDR_W = 8,
  parameter int T0H    = 8,
  parameter int T0L    = 24,
  parameter int T1H    = 16,
  parameter int T1L    = 16,
  parameter int TRESET = 2200,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_repeat,
  input  logic [ADDR_W:0]   i_num_pixels,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [BPP-1:0]    i_mem_data,
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  input  logic [7:0]        i_brightness,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_led_out
);

  localparam int BIT_W = $clog2(BPP);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  localparam logic [CNT_W-1:0]  C_T0H_LAST = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0]  C_T0L_LAST = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0]  C_T1H_LAST = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0]  C_T1L_LAST = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0]  C_TRST_LAST = CNT_W'(TRESET - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST = BIT_W'(BPP - 1);
  localparam logic [BIT_W-1:0]  C_BIT_ONE  = BIT_W'(1);
  localparam logic [ADDR_W:0]   C_PIX_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_TWO = ADDR_W'(2);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bit_idx;
  logic [ADDR_W:0]  r_pix_idx;
  logic [ADDR_W:0]  r_count;
  logic [BPP-1:0]   r_shift;
  logic [BPP-1:0]   r_pref;
  logic [1:0]       r_pf_dly;

  logic [BPP-1:0]   w_word;
  logic [CNT_W-1:0] w_hi_last;
  logic [CNT_W-1:0] w_lo_last;
  logic             w_last_bit;
  logic             w_last_pix;

`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  // Each 8-bit channel is scaled by brightness/256 as the word is captured.
  function automatic logic [BPP-1:0] f_scale(input logic [BPP-1:0] w, input logic [7:0] b);
    logic [15:0] p;
    f_scale = '0;
    for (int c = 0; c < BPP/8; c++) begin
      p = {8'd0, w[c*8 +: 8]} * {8'd0, b};
      f_scale[c*8 +: 8] = 8'(p >> 8);
    end
  endfunction

  assign w_word = f_scale(i_mem_data, i_brightness);
`else
  assign w_word = i_mem_data;
`endif

  assign w_hi_last  = r_shift[BPP-1] ? C_T1H_LAST : C_T0H_LAST;
  assign w_lo_last  = r_shift[BPP-1] ? C_T1L_LAST : C_T0L_LAST;
  assign w_last_bit = (r_bit_idx == C_BIT_LAST);
  assign w_last_pix = (r_pix_idx == (r_count - C_PIX_ONE));

  // The address is parked at 0 through LATCH and IDLE so the RAM output is
  // already mem[0] during the single FETCH cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_pix_idx  <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_pref     <= '0;
      r_pf_dly   <= '0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_led_out  <= 1'b0;
    end else begin
      o_done <= 1'b0;

      // Prefetch capture lands two edges after an address change: one edge for
      // the RAM to register the address, one to take its output.
      if (r_pf_dly != 2'd0) begin
        r_pf_dly <= r_pf_dly - 2'd1;
        if (r_pf_dly == 2'd1) r_pref <= w_word;
      end

      case (r_state)
        S_IDLE: begin
          o_led_out <= 1'b0;
          r_cnt     <= '0;
          if (i_start && (i_num_pixels != '0)) begin
            r_count    <= i_num_pixels;
            o_mem_addr <= '0;
            o_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_shift    <= w_word;
          r_bit_idx  <= '0;
          r_pix_idx  <= '0;
          o_mem_addr <= C_ADDR_ONE;
          r_pf_dly   <= 2'd2;
          r_cnt      <= '0;
          o_led_out  <= 1'b1;
          r_state    <= S_HIGH;
        end

        S_HIGH: begin
          if (r_cnt == w_hi_last) begin
            r_cnt     <= '0;
            o_led_out <= 1'b0;
            r_state   <= S_LOW;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        S_LOW: begin
          if (r_cnt == w_lo_last) begin
            r_cnt <= '0;
            if (!w_last_bit) begin
              r_shift   <= {r_shift[BPP-2:0], 1'b0};
              r_bit_idx <= r_bit_idx + C_BIT_ONE;
              o_led_out <= 1'b1;
              r_state   <= S_HIGH;
            end else if (!w_last_pix) begin
              r_shift    <= r_pref;
              r_bit_idx  <= '0;
              r_pix_idx  <= r_pix_idx + C_PIX_ONE;
              o_mem_addr <= r_pix_idx[ADDR_W-1:0] + C_ADDR_TWO;
              r_pf_dly   <= 2'd2;
              o_led_out  <= 1'b1;
              r_state    <= S_HIGH;
            end else begin
              o_mem_addr <= '0;
              r_state    <= S_LATCH;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        S_LATCH: begin
          o_led_out <= 1'b0;
          if (r_cnt == C_TRST_LAST) begin
            r_cnt  <= '0;
            o_done <= 1'b1;
            if (i_repeat && (i_num_pixels != '0)) begin
              r_count    <= i_num_pixels;
              o_mem_addr <= '0;
              r_state    <= S_FETCH;
            end else begin
              o_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        default: begin
          o_led_out <= 1'b0;
          o_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_tx_multi.sv
// Scoreboard bench for neopixel_tx_multi: decodes the serial line back into words and
// compares them, in order, with the words queued when each frame was started.
module tb_neopixel_tx_multi;

  localparam int T0H = 8, T0L = 24, T1H = 16, T1L = 16, TRESET = 2200, TRST_B = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, rep_a = 1'b0;
  logic [8:0]  num_a = '0;
  logic [7:0]  addr_a;
  logic [23:0] rd_a = '0;
  logic        busy_a, done_a, led_a;
  logic        start_b = 1'b0;
  logic [2:0]  num_b = '0;
  logic [1:0]  addr_b;
  logic [31:0] rd_b = '0;
  logic        busy_b, done_b, led_b;
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
  logic [7:0]  bright = 8'd128;
`endif

  logic [23:0] mem_a [256];
  logic [31:0] mem_b [4];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  int n_err = 0, n_chk = 0, cyc = 0;
  bit mon_en = 1'b1;

  neopixel_tx_multi u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_repeat(rep_a),
    .i_num_pixels(num_a), .o_mem_addr(addr_a), .i_mem_data(rd_a),
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    .i_brightness(bright),
`endif
    .o_busy(busy_a), .o_done(done_a), .o_led_out(led_a)
  );

  neopixel_tx_multi #(.BPP(32), .ADDR_W(2), .TRESET(TRST_B)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_repeat(1'b0),
    .i_num_pixels(num_b), .o_mem_addr(addr_b), .i_mem_data(rd_b),
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    .i_brightness(bright),
`endif
    .o_busy(busy_b), .o_done(done_b), .o_led_out(led_b)
  );

  always #5 clk = ~clk;

  // Synchronous pixel RAMs: data follows the registered address by one edge.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_a <= mem_a[addr_a];
    rd_b <= mem_b[addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] f_exp(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = 8'(({8'd0, w[c*8 +: 8]} * {8'd0, bright}) >> 8);
`endif
    return r;
  endfunction

  // Line decoder for DUT A: pulse widths, words and the latch gap.
  int a_h, a_l, a_nb;
  bit a_prev, a_have, a_lastb;
  logic [23:0] a_w;
  always @(negedge clk) begin
    if (!mon_en) begin
      a_h = 0; a_l = 0; a_nb = 0; a_prev = 0; a_have = 0; a_lastb = 0; a_w = '0;
    end else begin
      if (led_a) begin
        if (!a_prev) begin
          if (a_have) chk("low_width", a_l, a_lastb ? T1L : T0L);
          a_h = 0;
        end
        a_h++;
        a_l = 0;
      end else begin
        if (a_prev) begin
          a_lastb = (a_h > (T0H + T1H) / 2);
          chk("high_width", a_h, a_lastb ? T1H : T0H);
          a_w = {a_w[22:0], a_lastb};
          a_nb++;
          a_have = 1;
          if (a_nb == 24) begin
            a_nb = 0;
            if (exp_a.size() == 0) chk("extra_word_a", exp_a.size(), 1);
            else chk("word_a", {8'd0, a_w}, exp_a.pop_front());
          end
          a_l = 0;
        end
        a_l++;
      end
      if (done_a) begin
        if (a_have) chk("latch_width", a_l, (a_lastb ? T1L : T0L) + TRESET + 1);
        chk("partial_bits_a", a_nb, 0);
        a_have = 0;
      end
      a_prev = led_a;
    end
  end

  // Line decoder for DUT B (32-bit pixels).
  int b_h, b_nb;
  bit b_prev, b_bit;
  logic [31:0] b_w;
  initial begin b_h = 0; b_nb = 0; b_prev = 0; b_bit = 0; b_w = '0; end
  always @(negedge clk) begin
    if (led_b) begin
      if (!b_prev) b_h = 0;
      b_h++;
    end else if (b_prev) begin
      b_bit = (b_h > (T0H + T1H) / 2);
      chk("high_width_b", b_h, b_bit ? T1H : T0H);
      b_w = {b_w[30:0], b_bit};
      b_nb++;
      if (b_nb == 32) begin
        b_nb = 0;
        if (exp_b.size() == 0) chk("extra_word_b", exp_b.size(), 1);
        else chk("word_b", b_w, exp_b.pop_front());
      end
    end
    b_prev = led_b;
  end

  task automatic start_a_frame(input int n, input bit push);
    @(negedge clk);
    num_a   = 9'(n);
    start_a = 1'b1;
    if (push) for (int k = 0; k < n; k++) exp_a.push_back(f_exp({8'd0, mem_a[k]}));
    @(negedge clk);
    start_a = 1'b0;
    chk("fetch_led_low", led_a, 0);
    chk("busy_set", busy_a, 1);
    @(negedge clk);
    chk("first_rise", led_a, 1);
  endtask

  task automatic wait_done(input bit sel, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done_b : done_a;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    for (int k = 0; k < 256; k++) mem_a[k] = 24'h0;
    mem_b[0] = 32'h8000_0001; mem_b[1] = 32'h1234_5678;
    mem_b[2] = 32'hFF00_00FF; mem_b[3] = 32'h0F0F_F0F0;

    repeat (3) @(negedge clk);
    chk("rst_led", led_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_led_b", led_b, 0);
    rst = 1'b0;

    // Single pixel 0xA50000.
    mem_a[0] = 24'hA50000;
    start_a_frame(1, 1);
    wait_done(0, 4000);
    chk("busy_fall", busy_a, 0);
    @(negedge clk);
    chk("done_one_cycle", done_a, 0);
    chk("q_empty_1", exp_a.size(), 0);

    // Four pixels, walking one; start ignored and count changed mid-frame.
    for (int k = 0; k < 4; k++) mem_a[k] = 24'h000001 << k;
    start_a_frame(4, 1);
    num_a = 9'd1;
    repeat (1540) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 6000);
    chk("busy_fall_4", busy_a, 0);
    repeat (300) @(negedge clk);
    chk("no_restart_busy", busy_a, 0);
    chk("no_restart_led", led_a, 0);
    chk("q_empty_4", exp_a.size(), 0);

    // Zero pixel count: start ignored.
    num_a   = 9'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("zero_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    chk("zero_busy_later", busy_a, 0);
    chk("zero_led", led_a, 0);

    // Reset in the middle of a HIGH phase.
    start_a_frame(4, 1);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 100 && !led_a; i++) @(negedge clk);
    chk("high_before_rst", led_a, 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("midrst_led", led_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_addr", addr_a, 0);
    rst = 1'b0;
    exp_a.delete();
    @(negedge clk);
    mon_en = 1'b1;
    mem_a[0] = 24'h5A3C96;
    start_a_frame(1, 1);
    wait_done(0, 4000);
    @(negedge clk);
    chk("q_empty_rst", exp_a.size(), 0);

    // Auto-repeat with two pixels.
    mem_a[0] = 24'h123456;
    mem_a[1] = 24'hABCDEF;
    rep_a = 1'b1;
    start_a_frame(2, 1);
    for (int k = 0; k < 2; k++) exp_a.push_back(f_exp({8'd0, mem_a[k]}));
    wait_done(0, 5000);
    t1 = cyc;
    chk("rep_busy_held", busy_a, 1);
    rep_a = 1'b0;
    wait_done(0, 5000);
    t2 = cyc;
    chk("rep_period", t2 - t1, 1 + 48 * 32 + TRESET);
    @(negedge clk);
    chk("rep_q_empty", exp_a.size(), 0);
    chk("rep_busy_fall", busy_a, 0);

    // 32-bit pixels, full 4-entry frame on a 2-bit address.
    @(negedge clk);
    num_b   = 3'd4;
    start_b = 1'b1;
    for (int k = 0; k < 4; k++) exp_b.push_back(f_exp(mem_b[k]));
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1, 6000);
    chk("b_addr_wrap", addr_b, 0);
    chk("b_busy_fall", busy_b, 0);
    @(negedge clk);
    chk("b_q_empty", exp_b.size(), 0);

`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    // Half brightness on a full-scale green channel.
    bright   = 8'd128;
    mem_a[0] = 24'hFF0000;
    exp_a.push_back(32'h007F0000);
    start_a_frame(1, 0);
    wait_done(0, 4000);
    @(negedge clk);
    chk("bright_q_empty", exp_a.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
